// File: rtl/spike_log_pkg.sv
// Shared types and defaults for the spike logger.
package spike_log_pkg;

   localparam int unsigned TS_W_DEFAULT = 16;

   typedef logic [TS_W_DEFAULT-1:0] ts_t;

   // Refractory FSM: IDLE accepts spikes, DEAD ignores them until rcnt expires.
   typedef enum logic [0:0] {
      IDLE = 1'b0,
      DEAD = 1'b1
   } rstate_t;

endpackage

// File: rtl/spike_logger_if.sv
// Timestamp readout handshake: master drives data/valid, slave drives ready.
interface spike_logger_if
   import spike_log_pkg::*;
#(
   parameter int unsigned TS_W = TS_W_DEFAULT
);
   logic [TS_W-1:0] ts_data;
   logic            ts_valid;
   logic            ts_ready;

   modport master (
      output ts_data,
      output ts_valid,
      input  ts_ready
   );

   modport slave (
      input  ts_data,
      input  ts_valid,
      output ts_ready
   );
endinterface

// File: rtl/spike_logger_ts_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers and optional overwrite-on-full.
module ts_fifo
   import spike_log_pkg::*;
#(
   parameter int unsigned W     = TS_W_DEFAULT,
   parameter int unsigned DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clear,
   input  logic         push,
   input  logic         pop,
   input  logic         overwrite,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0]  wptr_q;
   logic [AW:0]  rptr_q;
   logic [W-1:0] mem_q [DEPTH];
   logic         do_pop;
   logic         do_write;
   logic         do_ovr;

   // Status decode and write/pop qualification.
   always_comb begin
      empty    = (wptr_q == rptr_q);
      full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      do_pop   = pop & ~empty;
      // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
      do_write = push & (~full | do_pop);
      // Full, no pop: the write lands on the oldest slot and both pointers move.
      do_ovr   = push & full & ~do_pop & overwrite;
      rdata    = mem_q[rptr_q[AW-1:0]];
   end

   // Storage array.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (do_write | do_ovr) begin
         mem_q[wptr_q[AW-1:0]] <= wdata;
      end
   end

   // Read and write pointers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else if (clear) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_write | do_ovr) wptr_q <= wptr_q + 1'b1;
         if (do_pop | do_ovr)   rptr_q <= rptr_q + 1'b1;
      end
   end

endmodule

// File: rtl/spike_logger.sv
// Spike logger: timestamps accepted spikes, applies a refractory window and
// queues timestamps in a FWFT FIFO for readout.
// Build option: SPIKE_LOG_OVERWRITE_EN makes a full FIFO drop its oldest entry
// instead of the new timestamp.
module spike_logger
   import spike_log_pkg::*;
#(
   parameter int unsigned TS_W    = TS_W_DEFAULT,
   parameter int unsigned DEPTH   = 8,
   parameter int unsigned REFRACT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  sample_en,
   input  logic                  spike,
   input  logic                  clear,
   spike_logger_if.master        rd,
   output logic                  overflow,
   output logic [TS_W-1:0]       spike_cnt
);

   localparam int unsigned RC_W = (REFRACT > 0) ? $clog2(REFRACT + 1) : 1;

   rstate_t         state_q, state_d;
   logic [RC_W-1:0] rcnt_q, rcnt_d;
   logic [TS_W-1:0] ts_q;
   logic [TS_W-1:0] cnt_q;
   logic            ovf_q;
   logic            accept;
   logic            fifo_full;
   logic            fifo_empty;
   logic            pop;
   logic            drop;
   logic            ovr_en;
   logic [TS_W-1:0] head;

`ifdef SPIKE_LOG_OVERWRITE_EN
   assign ovr_en = 1'b1;
`else
   assign ovr_en = 1'b0;
`endif

   // Refractory next-state: only sample strobes move the FSM or rcnt.
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      accept  = 1'b0;
      if (sample_en) begin
         case (state_q)
            IDLE: begin
               if (spike) begin
                  accept = 1'b1;
                  if (REFRACT > 0) begin
                     state_d = DEAD;
                     rcnt_d  = RC_W'(REFRACT);
                  end
               end
            end
            DEAD: begin
               rcnt_d = rcnt_q - 1'b1;
               if (rcnt_q == RC_W'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // Handshake decode and overflow detection.
   always_comb begin
      pop         = ~fifo_empty & rd.ts_ready;
      drop        = accept & fifo_full & ~pop;
      rd.ts_valid = ~fifo_empty;
      rd.ts_data  = head;
      overflow    = ovf_q;
      spike_cnt   = cnt_q;
   end

   // FSM state and refractory counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rcnt_q  <= '0;
      end else if (clear) begin
         state_q <= IDLE;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
      end
   end

   // Timestamp counter, accepted-spike counter and sticky overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else if (clear) begin
         ts_q  <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         if (sample_en) ts_q  <= ts_q + 1'b1;
         if (accept)    cnt_q <= cnt_q + 1'b1;
         if (drop)      ovf_q <= 1'b1;
      end
   end

   // The logged value is the counter before this edge's increment.
   ts_fifo #(
      .W     (TS_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (clear),
      .push      (accept),
      .pop       (pop),
      .overwrite (ovr_en),
      .wdata     (ts_q),
      .rdata     (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_spike_logger.sv
// Directed bench for spike_logger: three instances cover the default build,
// REFRACT=0 with DEPTH=8, and TS_W=4 for timestamp wrap.
module tb_spike_logger;

   logic clk;
   logic rst;
   logic se  [3];
   logic sp  [3];
   logic cl  [3];
   logic rdy [3];

   logic        ovf_a, ovf_b, ovf_c;
   logic [15:0] cnt_a, cnt_b;
   logic [3:0]  cnt_c;

   int n_checks;
   int n_pass;

   spike_logger_if #(.TS_W(16)) if_a ();
   spike_logger_if #(.TS_W(16)) if_b ();
   spike_logger_if #(.TS_W(4))  if_c ();

   assign if_a.ts_ready = rdy[0];
   assign if_b.ts_ready = rdy[1];
   assign if_c.ts_ready = rdy[2];

   spike_logger #(.TS_W(16), .DEPTH(8), .REFRACT(4)) u_a (
      .clk       (clk),
      .rst       (rst),
      .sample_en (se[0]),
      .spike     (sp[0]),
      .clear     (cl[0]),
      .rd        (if_a),
      .overflow  (ovf_a),
      .spike_cnt (cnt_a)
   );

   spike_logger #(.TS_W(16), .DEPTH(8), .REFRACT(0)) u_b (
      .clk       (clk),
      .rst       (rst),
      .sample_en (se[1]),
      .spike     (sp[1]),
      .clear     (cl[1]),
      .rd        (if_b),
      .overflow  (ovf_b),
      .spike_cnt (cnt_b)
   );

   spike_logger #(.TS_W(4), .DEPTH(8), .REFRACT(0)) u_c (
      .clk       (clk),
      .rst       (rst),
      .sample_en (se[2]),
      .spike     (sp[2]),
      .clear     (cl[2]),
      .rd        (if_c),
      .overflow  (ovf_c),
      .spike_cnt (cnt_c)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   // Advance to just after the next active edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One sample strobe on instance d, with or without a spike.
   task automatic strobe(input int d, input logic s);
      se[d] = 1'b1;
      sp[d] = s;
      tick();
      se[d] = 1'b0;
      sp[d] = 1'b0;
   endtask

   int exp_first;

   initial begin
      n_checks = 0;
      n_pass   = 0;
      for (int i = 0; i < 3; i++) begin
         se[i] = 1'b0; sp[i] = 1'b0; cl[i] = 1'b0; rdy[i] = 1'b0;
      end
      rst = 1'b1;
      #22;
      rst = 1'b0;
      tick();

      // Reset state
      check_eq("rst_valid", {31'b0, if_a.ts_valid}, 0);
      check_eq("rst_data", {16'b0, if_a.ts_data}, 0);
      check_eq("rst_ovf", {31'b0, ovf_a}, 0);
      check_eq("rst_cnt", {16'b0, cnt_a}, 0);

      // Single spike on strobe 5
      rdy[0] = 1'b1;
      for (int i = 0; i < 5; i++) strobe(0, 1'b0);
      check_eq("single_pre_valid", {31'b0, if_a.ts_valid}, 0);
      strobe(0, 1'b1);
      check_eq("single_valid", {31'b0, if_a.ts_valid}, 1);
      check_eq("single_data", {16'b0, if_a.ts_data}, 5);
      check_eq("single_cnt", {16'b0, cnt_a}, 1);
      tick();
      check_eq("single_popped", {31'b0, if_a.ts_valid}, 0);

      // Refractory window: strobes 10..15 all spiking, idle gaps inside the window
      rdy[0] = 1'b0;
      for (int i = 6; i < 10; i++) strobe(0, 1'b0);
      strobe(0, 1'b1);  // 10 accepted
      strobe(0, 1'b1);  // 11
      strobe(0, 1'b1);  // 12
      sp[0] = 1'b1;
      tick(); tick(); tick();
      sp[0] = 1'b0;
      strobe(0, 1'b1);  // 13
      strobe(0, 1'b1);  // 14
      strobe(0, 1'b1);  // 15 accepted
      check_eq("refr_cnt", {16'b0, cnt_a}, 3);
      check_eq("refr_head", {16'b0, if_a.ts_data}, 10);
      rdy[0] = 1'b1;
      tick();
      check_eq("refr_second", {16'b0, if_a.ts_data}, 15);
      check_eq("refr_second_valid", {31'b0, if_a.ts_valid}, 1);
      tick();
      check_eq("refr_empty", {31'b0, if_a.ts_valid}, 0);
      check_eq("refr_ovf", {31'b0, ovf_a}, 0);
      rdy[0] = 1'b0;

      // Fill three entries (20, 25, 30), then async reset between edges
      for (int i = 16; i <= 30; i++) strobe(0, 1'b1);
      check_eq("mid_cnt", {16'b0, cnt_a}, 6);
      check_eq("mid_head", {16'b0, if_a.ts_data}, 20);
      #2;
      rst = 1'b1;
      #1;
      check_eq("arst_valid", {31'b0, if_a.ts_valid}, 0);
      check_eq("arst_ovf", {31'b0, ovf_a}, 0);
      check_eq("arst_cnt", {16'b0, cnt_a}, 0);
      check_eq("arst_data", {16'b0, if_a.ts_data}, 0);
      #1;
      rst = 1'b0;
      tick();
      strobe(0, 1'b1);
      check_eq("arst_next_valid", {31'b0, if_a.ts_valid}, 1);
      check_eq("arst_next_ts", {16'b0, if_a.ts_data}, 0);
      check_eq("arst_next_cnt", {16'b0, cnt_a}, 1);

      // Overflow: REFRACT=0, ready low, 10 spikes on strobes 0..9
`ifdef SPIKE_LOG_OVERWRITE_EN
      exp_first = 2;
`else
      exp_first = 0;
`endif
      for (int i = 0; i < 10; i++) strobe(1, 1'b1);
      check_eq("ovf_flag", {31'b0, ovf_b}, 1);
      check_eq("ovf_cnt", {16'b0, cnt_b}, 10);
      rdy[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check_eq($sformatf("ovf_drain%0d", i), {16'b0, if_b.ts_data}, 32'(exp_first + i));
         tick();
      end
      check_eq("ovf_drained", {31'b0, if_b.ts_valid}, 0);
      rdy[1] = 1'b0;

      // Clear while valid and overflow are set
      for (int i = 0; i < 3; i++) strobe(1, 1'b1);
      check_eq("pre_clr_valid", {31'b0, if_b.ts_valid}, 1);
      check_eq("pre_clr_ovf", {31'b0, ovf_b}, 1);
      cl[1] = 1'b1;
      se[1] = 1'b1;
      sp[1] = 1'b1;
      tick();
      cl[1] = 1'b0;
      se[1] = 1'b0;
      sp[1] = 1'b0;
      check_eq("clr_valid", {31'b0, if_b.ts_valid}, 0);
      check_eq("clr_ovf", {31'b0, ovf_b}, 0);
      check_eq("clr_cnt", {16'b0, cnt_b}, 0);

      // Refill to full (0..7), then push and pop together
      for (int i = 0; i < 8; i++) strobe(1, 1'b1);
      check_eq("clr_ts_zero", {16'b0, if_b.ts_data}, 0);
      check_eq("full_ovf", {31'b0, ovf_b}, 0);
      rdy[1] = 1'b1;
      strobe(1, 1'b1);
      check_eq("pp_ovf", {31'b0, ovf_b}, 0);
      check_eq("pp_cnt", {16'b0, cnt_b}, 9);
      for (int i = 1; i <= 8; i++) begin
         check_eq($sformatf("pp_drain%0d", i), {16'b0, if_b.ts_data}, 32'(i));
         tick();
      end
      check_eq("pp_empty", {31'b0, if_b.ts_valid}, 0);
      rdy[1] = 1'b0;

      // Timestamp wrap with TS_W=4: spikes on strobes 15 and 17
      for (int i = 0; i < 18; i++) strobe(2, (i == 15 || i == 17));
      check_eq("wrap_cnt", {28'b0, cnt_c}, 2);
      check_eq("wrap_first", {28'b0, if_c.ts_data}, 15);
      rdy[2] = 1'b1;
      tick();
      check_eq("wrap_second", {28'b0, if_c.ts_data}, 1);
      tick();
      check_eq("wrap_empty", {31'b0, if_c.ts_valid}, 0);
      tick();
      tick();
      check_eq("ready_empty_noop", {31'b0, if_c.ts_valid}, 0);
      check_eq("wrap_ovf", {31'b0, ovf_c}, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/spike_logger.md
Name: spike_logger

Overview:
- Downstream consumer of the spike detector's single-bit `spike` output.
- Timestamps each accepted spike with a free-running sample counter and applies a refractory (dead-time) window, so one spike cannot be logged twice.
- Buffers the timestamps in a small first-word-fall-through (FWFT) FIFO.
- Delivers the timestamps to a readout/host interface over a valid/ready handshake.

Parameters:
- TS_W, 16, width of the sample timestamp counter and of each logged word.
- DEPTH, 8, number of FIFO entries; power of two, minimum 2.
- REFRACT, 4, number of sample strobes ignored after an accepted spike; 0 disables the window.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- sample_en  in  1  sample strobe; high on cycles when the detector output is valid (same strobe as the detector's `enable`).
- spike  in  1  detector spike flag; sampled only when sample_en=1.
- clear  in  1  synchronous clear of timestamp, FIFO, refractory state and overflow flag.
- ts_data  out  TS_W  timestamp at the FIFO head.
- ts_valid  out  1  FIFO not empty.
- ts_ready  in  1  consumer accepts ts_data when ts_valid & ts_ready.
- overflow  out  1  sticky: at least one spike was lost because the FIFO was full.
- spike_cnt  out  TS_W  count of accepted spikes, wraps modulo 2^TS_W.

Behaviour:
- Reset (async, rst=1): all registers clear immediately.
  - ts_data=0, ts_valid=0, overflow=0, spike_cnt=0.
  - timestamp=0, FIFO empty, FSM=IDLE.
- clear=1 has the same effect as reset on the next clock edge. It has priority over every other input that cycle.
- Timestamp counter:
  - Increments by 1 on every sample_en cycle.
  - Wraps from 2^TS_W-1 to 0 with no flag.
  - The logged value is the counter value before the increment on that same edge.
- Refractory FSM, states IDLE and DEAD, with a down-counter rcnt:
  - IDLE & sample_en & spike: accept the spike. If REFRACT>0, go to DEAD with rcnt=REFRACT.
  - DEAD & sample_en: rcnt decrements. When rcnt reaches 0, return to IDLE. Spikes seen in DEAD are ignored, not counted and not flagged.
  - Cycles with sample_en=0 never change the FSM or rcnt.
  - REFRACT=0: the FSM stays in IDLE and every spike strobe is accepted.
- Accept action:
  - spike_cnt increments.
  - Push the timestamp if the FIFO is not full, or if a pop happens in the same cycle.
  - Otherwise drop the timestamp and set overflow. spike_cnt still increments.
- FIFO (FWFT):
  - ts_valid = not empty; ts_data = head entry.
  - Pop when ts_valid & ts_ready.
  - ts_ready while empty has no effect.
  - Simultaneous push and pop is legal at any occupancy, including full and empty+1; occupancy is unchanged.
  - Push into an empty FIFO: ts_valid rises on the cycle after the accepting edge (latency 1).
  - ts_data must be held stable while ts_valid=1 and ts_ready=0.
- Pointers are log2(DEPTH) bits plus one extra wrap bit; full/empty are decoded from the pointers. No combinational path from ts_ready to ts_valid.

Optional Feature:
- SPIKE_LOG_OVERWRITE_EN defined: an accepted spike with the FIFO full and no pop overwrites the oldest entry.
  - The read and write pointers both advance; the FIFO keeps the newest DEPTH timestamps.
  - overflow is still set.
- Not defined: the new spike is dropped and the FIFO contents are preserved (default).

Decomposition:
- spike_log_pkg holds:
  - TS_W default constant.
  - typedef ts_t (logic [TS_W-1:0]).
  - FSM enum rstate_t {IDLE, DEAD}.
- Sub-module ts_fifo: parameterised FWFT FIFO with push/pop, full/empty and the optional overwrite input.
- spike_logger contains the timestamp counter, the refractory FSM, spike_cnt and overflow, and instantiates ts_fifo.

Test Plan:
- Reset mid-operation: FIFO holding 3 entries, rst pulsed asynchronously between edges -> ts_valid=0, overflow=0, spike_cnt=0 immediately; the next accepted spike is logged with timestamp 0.
- Single spike: sample_en every cycle, spike on strobe 5, ts_ready=1 -> ts_valid high one cycle later with ts_data=5; spike_cnt=1.
- Refractory, REFRACT=4: spikes on strobes 10,11,12,13,14,15 -> only 10 and 15 logged; spike_cnt=2. Idle cycles with sample_en=0 inserted between strobes do not shorten the window.
- Overflow, DEPTH=8, REFRACT=0, ts_ready=0: 10 consecutive spikes on strobes 0..9 -> FIFO holds 0..7, overflow=1, spike_cnt=10.
  - Repeat with SPIKE_LOG_OVERWRITE_EN -> FIFO holds 2..9.
- Full with simultaneous push and pop: FIFO full, ts_ready=1 and an accepted spike in the same cycle -> no overflow; the head advances and the new timestamp is placed at the tail.
- Timestamp wrap, TS_W=4: spikes at strobes 15 and 17 -> logged 15 then 1.
- clear while ts_valid=1 and overflow=1 -> next cycle ts_valid=0, overflow=0, timestamp=0.
